// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a WIDTH-step shift-add
// multiplier and restoring divider sharing one iteration datapath.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             mode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             za,
  output logic             zb,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             zr,
  output logic             cy,
  output logic             dz
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_l, b_l;
  logic [2:0]       op_l;
  logic             mode_l;
  logic [WIDTH-1:0] acc, lo;
  logic [CW-1:0]    cnt;

  logic             needs_iter, iter_last, commit;
  logic [WIDTH:0]   sum, mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] ex_res, ex_hi, acc_n, lo_n, fin_res, fin_hi;
  logic             ex_cy, ex_dz;

  assign needs_iter = !mode && (opcode == OP_MUL || opcode == OP_DIV) && (b != '0);
  assign iter_last  = (cnt == CW'(WIDTH));
  assign commit     = (state == EXEC) || (state == ITER && iter_last);

  // NOTE: every signal driven in an always_comb gets a default first so no path
  // leaves it unassigned and a latch is inferred.
  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      IDLE:    if (start) state_n = needs_iter ? ITER : EXEC;
      EXEC:    state_n = DONE;
      ITER:    if (iter_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Single-cycle operations on the latched operands.
  always_comb begin
    ex_res = '0;
    ex_hi  = '0;
    ex_cy  = 1'b0;
    ex_dz  = 1'b0;
    sum    = '0;
    if (!mode_l) begin
      case (op_l)
        3'd0: begin sum = {1'b0, a_l} + {1'b0, b_l}; ex_res = sum[WIDTH-1:0]; ex_cy = sum[WIDTH]; end
        3'd1: begin ex_res = a_l - b_l; ex_cy = (a_l < b_l); end
        3'd2: begin sum = {1'b0, a_l} + 1'b1; ex_res = sum[WIDTH-1:0]; ex_cy = sum[WIDTH]; end
        3'd3: begin ex_res = a_l - 1'b1; ex_cy = (a_l == '0); end
        3'd4: ex_res = '0;  // only reached with b == 0, product is zero
        3'd5: begin ex_res = '1; ex_hi = a_l; ex_dz = 1'b1; end
        3'd6: ex_res = '0 - a_l;
        default: ex_res = a_l;
      endcase
    end else begin
      case (op_l)
        3'd0: ex_res = a_l & b_l;
        3'd1: ex_res = a_l | b_l;
        3'd2: ex_res = a_l ^ b_l;
        3'd3: ex_res = ~(a_l & b_l);
        3'd4: ex_res = ~(a_l | b_l);
        3'd5: ex_res = ~(a_l ^ b_l);
        3'd6: ex_res = ~a_l;
        default: ex_res = a_l << b_l[SW-1:0];
      endcase
    end
  end

  // One iteration step; acc holds the product high half or the partial remainder,
  // lo holds the multiplier/product low half or the dividend/quotient.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, a_l} : '0);
    div_sh  = {acc, lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, b_l});
    if (op_l == OP_DIV) begin
      acc_n = div_ge ? WIDTH'(div_sh - {1'b0, b_l}) : div_sh[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
    end
    fin_res = (state == ITER) ? lo  : ex_res;
    fin_hi  = (state == ITER) ? acc : ex_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_l       <= '0;
      b_l       <= '0;
      op_l      <= '0;
      mode_l    <= 1'b0;
      acc       <= '0;
      lo        <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      {za, zb, eq, gt, lt, zr, cy, dz} <= '0;
    end else begin
      if (state == IDLE && start) begin
        a_l    <= a;
        b_l    <= b;
        op_l   <= opcode;
        mode_l <= mode;
        acc    <= '0;
        lo     <= (opcode == OP_DIV) ? a : b;
        cnt    <= '0;
      end else if (state == ITER && !iter_last) begin
        acc <= acc_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
      end
      if (commit) begin
        result    <= fin_res;
        result_hi <= fin_hi;
        cy        <= (state == EXEC) && ex_cy;
        dz        <= (state == EXEC) && ex_dz;
        zr        <= (fin_res == '0);
        za        <= (a_l == '0);
        zb        <= (b_l == '0);
        eq        <= (a_l == b_l);
        gt        <= (a_l > b_l);
        lt        <= (a_l < b_l);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued when a request is
// accepted and compared when the done pulse appears.
module tb_alu_seq;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [7:0]   flags;  // {za, zb, eq, gt, lt, zr, cy, dz}
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   opcode = '0;
  logic         mode = 1'b0, start = 1'b0;
  logic         busy, done, za, zb, eq, gt, lt, zr, cy, dz;
  logic [W-1:0] result, result_hi;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode), .mode(mode),
    .start(start), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt),
    .zr(zr), .cy(cy), .dz(dz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic m, input logic [2:0] op,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   t;
    logic [2*W-1:0] p;
    logic [3:0]   sh;
    logic         c, z;
    e.res = '0; e.hi = '0; e.lat = 1; c = 1'b0; z = 1'b0;
    sh = y[3:0];
    if (!m) begin
      case (op)
        3'd0: begin t = {1'b0, x} + {1'b0, y}; e.res = t[W-1:0]; c = t[W]; end
        3'd1: begin e.res = x - y; c = (x < y); end
        3'd2: begin t = {1'b0, x} + 17'd1; e.res = t[W-1:0]; c = t[W]; end
        3'd3: begin e.res = x - 16'd1; c = (x == 0); end
        3'd4: begin
          p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          e.res = p[W-1:0]; e.hi = p[2*W-1:W];
          e.lat = (y != 0) ? W + 1 : 1;
        end
        3'd5: begin
          if (y == 0) begin e.res = '1; e.hi = x; z = 1'b1; end
          else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
        end
        3'd6: e.res = ~x + 16'd1;
        default: e.res = x;
      endcase
    end else begin
      case (op)
        3'd0: e.res = x & y;
        3'd1: e.res = x | y;
        3'd2: e.res = x ^ y;
        3'd3: e.res = ~(x & y);
        3'd4: e.res = ~(x | y);
        3'd5: e.res = ~(x ^ y);
        3'd6: e.res = ~x;
        default: e.res = x << sh;
      endcase
    end
    e.flags = {x == 0, y == 0, x == y, x > y, x < y, e.res == 0, c, z};
    return e;
  endfunction

  // Issues one request, then waits for done and scores it against the queue head.
  task automatic run_op(input logic m, input logic [2:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    exp_t e;
    int   n;
    sb.push_back(model(m, op, x, y));
    @(negedge clk);
    a = x; b = y; mode = m; opcode = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; opcode = 3'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy: got %b expected 1 (cycle %0d)", name, busy, n);
      end
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
    end
    total++;
    if (result !== e.res) begin
      bad++;
      $display("FAIL %s result: got %h expected %h", name, result, e.res);
    end
    total++;
    if (result_hi !== e.hi) begin
      bad++;
      $display("FAIL %s result_hi: got %h expected %h", name, result_hi, e.hi);
    end
    total++;
    if ({za, zb, eq, gt, lt, zr, cy, dz} !== e.flags) begin
      bad++;
      $display("FAIL %s flags: got %b expected %b", name, {za, zb, eq, gt, lt, zr, cy, dz}, e.flags);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, result, result_hi, za, zb, eq, gt, lt, zr, cy, dz} !== '0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b res=%h hi=%h expected all 0",
               busy, done, result, result_hi);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_carry();
    run_op(1'b0, 3'd0, 16'hFFFF, 16'h0001, "add_wrap");
    total++;
    if (result !== 16'h0000 || cy !== 1'b1 || zr !== 1'b1) begin
      bad++;
      $display("FAIL add_wrap_hold: got res=%h cy=%b zr=%b expected 0000 1 1", result, cy, zr);
    end
  endtask

  task automatic test_mul();
    run_op(1'b0, 3'd4, 16'h1234, 16'h0010, "mul");
    total++;
    if (result !== 16'h2340 || result_hi !== 16'h0001) begin
      bad++;
      $display("FAIL mul_hold: got %h_%h expected 0001_2340", result_hi, result);
    end
    run_op(1'b0, 3'd4, 16'hFFFF, 16'hFFFF, "mul_max");
    run_op(1'b0, 3'd4, 16'h00AB, 16'h0000, "mul_b0");
  endtask

  task automatic test_div();
    run_op(1'b0, 3'd5, 16'd100, 16'd7, "div");
    total++;
    if (result !== 16'd14 || result_hi !== 16'd2) begin
      bad++;
      $display("FAIL div_hold: got q=%0d r=%0d expected 14 2", result, result_hi);
    end
    run_op(1'b0, 3'd5, 16'h00AB, 16'h0000, "div_zero");
    total++;
    if (result !== 16'hFFFF || result_hi !== 16'h00AB || dz !== 1'b1 || zb !== 1'b1) begin
      bad++;
      $display("FAIL div_zero_hold: got %h %h dz=%b zb=%b expected FFFF 00AB 1 1",
               result, result_hi, dz, zb);
    end
    run_op(1'b0, 3'd5, 16'hFFFF, 16'h0001, "div_by1");
    run_op(1'b0, 3'd5, 16'h0003, 16'h8000, "div_small");
  endtask

  task automatic test_cmp();
    run_op(1'b1, 3'd0, 16'd5, 16'd9, "cmp_and");
    total++;
    if (lt !== 1'b1 || gt !== 1'b0 || eq !== 1'b0 || result !== 16'h0001) begin
      bad++;
      $display("FAIL cmp_hold: got lt=%b gt=%b eq=%b res=%h expected 1 0 0 0001", lt, gt, eq, result);
    end
    run_op(1'b1, 3'd1, 16'h0000, 16'h0000, "cmp_zero");
    run_op(1'b0, 3'd1, 16'h0007, 16'h0007, "sub_eq");
  endtask

  task automatic test_all_ops();
    logic [W-1:0] x, y;
    for (int i = 0; i < 48; i++) begin
      x = $urandom;
      y = (i % 7 == 3) ? '0 : ((i % 5 == 1) ? x : W'($urandom));
      run_op(1'(i / 8 % 2), 3'(i % 8), x, y, $sformatf("op%0d_%0d", i / 8 % 2, i % 8));
    end
    run_op(1'b0, 3'd3, 16'h0000, 16'h0000, "dec_borrow");
    run_op(1'b0, 3'd2, 16'hFFFF, 16'h0000, "inc_carry");
    run_op(1'b0, 3'd6, 16'h0001, 16'h0000, "neg");
    run_op(1'b1, 3'd7, 16'h8001, 16'h0013, "lsl");
  endtask

  // A second start mid-multiply and another during the done cycle are both ignored.
  task automatic test_back_to_back();
    exp_t e;
    int   n;
    sb.push_back(model(1'b0, 3'd4, 16'h1234, 16'h0010));
    @(negedge clk);
    a = 16'h1234; b = 16'h0010; mode = 1'b0; opcode = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (n == 5) begin a = 16'h0F0F; b = 16'h0003; opcode = 3'd0; start = 1'b1; end
      if (n == 7) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    total++;
    if (n !== e.lat || result !== e.res || result_hi !== e.hi) begin
      bad++;
      $display("FAIL b2b_mul: got n=%0d %h_%h expected n=%0d %h_%h",
               n, result_hi, result, e.lat, e.hi, e.res);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_start: got busy=%b done=%b expected 0 0", busy, done);
    end
    run_op(1'b0, 3'd0, 16'h0F0F, 16'h0003, "b2b_next");
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h0010; mode = 1'b0; opcode = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0) begin
      bad++;
      $display("FAIL rst_mid: got busy=%b done=%b res=%h hi=%h expected 0 0 0 0",
               busy, done, result, result_hi);
    end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (done) seen++; end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_mid_done: got %0d done pulses expected 0", seen);
    end
    run_op(1'b0, 3'd0, 16'd3, 16'd4, "rst_add");
    total++;
    if (result !== 16'd7) begin
      bad++;
      $display("FAIL rst_add_hold: got %0d expected 7", result);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_mul();
    test_div();
    test_cmp();
    test_all_ops();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
